alu_seq: RTL

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with single-cycle logic/arithmetic ops and an
//    optional shift-add multiplier (compiled in when ALU_MUL_EN is defined).
// Latency: 1 cycle for sel 000..110 (and 111 without ALU_MUL_EN), WIDTH+1
//    cycles for the multiply. Backpressure: none; start is ignored while busy.
// Ports:
//    clk, rst        - clock, synchronous active-high reset
//    start, sel      - request an operation, operation select
//    a, b, c         - operands (sampled on the accepting edge)
//    out, ovr        - registered result and overflow/borrow flag
//    busy, done      - multiply in progress, one-cycle result-valid pulse
// Configuration macro: ALU_MUL_EN (multiply datapath, MUL state, counter).
module alu_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       sel,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   output logic [WIDTH-1:0] out,
   output logic             ovr,
   output logic             busy,
   output logic             done
);

`ifdef ALU_MUL_EN
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int CW = $clog2(WIDTH);
`else
   typedef enum logic {
      IDLE = 1'b0,
      DONE = 1'b1
   } state_t;
`endif

   state_t state;

   // Single-cycle result, computed straight from the live operands so the
   // accepting edge captures it; later operand changes cannot reach out.
   logic [WIDTH-1:0] res;
   logic             res_ovr;
   logic [WIDTH:0]   sum;

   always_comb begin
      sum     = {1'b0, a} + {1'b0, b};
      res     = '0;
      res_ovr = 1'b0;
      case (sel)
         3'b000: begin
            res     = a - b;
            res_ovr = (a < b);
         end
         3'b001: begin
            res     = b - a;
            res_ovr = (b < a);
         end
         3'b010: begin
            res     = sum[WIDTH-1:0];
            res_ovr = sum[WIDTH];
         end
         3'b011: res = a & b;
         3'b100: res = a | b;
         3'b101: res = a ^ b;
         3'b110: res = ~c;
         default: begin
            res     = '0;
            res_ovr = 1'b0;
         end
      endcase
   end

`ifdef ALU_MUL_EN
   // Shift-add multiplier: mcand is shifted left and mplier right each
   // iteration, so mplier[0] is always the multiplier bit for this cycle.
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] mcand;
   logic [WIDTH-1:0]   mplier;
   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] acc_nxt;
   logic               last_iter;

   always_comb begin
      acc_nxt   = acc + (mplier[0] ? mcand : '0);
      last_iter = (cnt == CW'(WIDTH - 1));
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         out    <= '0;
         ovr    <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
`ifdef ALU_MUL_EN
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         cnt    <= '0;
`endif
      end else begin
         done <= 1'b0;
         busy <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (start) begin
`ifdef ALU_MUL_EN
                  if (sel == 3'b111) begin
                     // out/ovr keep the previous result during MUL
                     state  <= MUL;
                     busy   <= 1'b1;
                     acc    <= '0;
                     mcand  <= {{WIDTH{1'b0}}, a};
                     mplier <= b;
                     cnt    <= '0;
                  end else begin
                     state <= DONE;
                     done  <= 1'b1;
                     out   <= res;
                     ovr   <= res_ovr;
                  end
`else
                  state <= DONE;
                  done  <= 1'b1;
                  out   <= res;
                  ovr   <= res_ovr;
`endif
               end else begin
                  state <= IDLE;
               end
            end
`ifdef ALU_MUL_EN
            MUL: begin
               acc    <= acc_nxt;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + CW'(1);
               if (last_iter) begin
                  state <= DONE;
                  done  <= 1'b1;
                  out   <= acc_nxt[WIDTH-1:0];
                  ovr   <= |acc_nxt[2*WIDTH-1:WIDTH];
               end else begin
                  busy <= 1'b1;
               end
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end

endmodule
